hazard_free_flag_mc: RTL and testbench

//  Multi-channel, glitch-filtered condition flag. Per channel, din is synchronised, ANDed with en,
//  and the result must hold for FILT_CYC consecutive cycles before the registered flag follows it.

---
 rtl/hazard_free_flag_mc.sv | 76 +++++++
 tb/tb_hazard_free_flag_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_free_flag_mc.sv
// Multi-channel glitch-filtered condition flag: synchronised din gated by en must persist
// FILT_CYC cycles before the registered flag follows; adds rise/fall pulses and any_flag.
module hazard_free_flag_mc #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] flag,
  output logic [CH-1:0] flag_rise,
  output logic [CH-1:0] flag_fall,
  output logic          any_flag
);

  localparam int unsigned CNT_W = $clog2(FILT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
  logic [CH-1:0]                  din_s;
  logic [CH-1:0]                  cond;
  logic [CH-1:0][CNT_W-1:0]       cnt_q;
  logic [CH-1:0][CNT_W-1:0]       cnt_d;
  logic [CH-1:0]                  flag_d;

  // Synchroniser chain; stage 0 samples the raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign din_s = sync_q[SYNC_STAGES-1];
  assign cond  = din_s & en;

  // Per-channel filter: a disagreement must persist FILT_CYC cycles; any agreement restarts it.
  always_comb begin
    flag_d = flag;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(CH); i++) begin
      if (!en[i]) begin
        flag_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (cond[i] == flag[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        flag_d[i] = cond[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Outputs derive from next_flag so pulses and any_flag line up with flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      flag      <= '0;
      flag_rise <= '0;
      flag_fall <= '0;
      any_flag  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      flag      <= flag_d;
      flag_rise <= flag_d & ~flag;
      flag_fall <= ~flag_d & flag;
      any_flag  <= |flag_d;
    end
  end

endmodule

// File: tb/tb_hazard_free_flag_mc.sv
// Bench for hazard_free_flag_mc: default config (A) and SYNC_STAGES=3/FILT_CYC=1 (B) side by side,
// compared each cycle against a delay-line + streak reference model, plus directed latency checks.
module tb_hazard_free_flag_mc;

  localparam int unsigned CH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] en  = '1;
  logic [CH-1:0] din = '1;

  logic [CH-1:0] flag_a, rise_a, fall_a;
  logic [CH-1:0] flag_b, rise_b, fall_b;
  logic          any_a, any_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_free_flag_mc u_dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .flag(flag_a), .flag_rise(rise_a), .flag_fall(fall_a), .any_flag(any_a)
  );

  hazard_free_flag_mc #(.CH(CH), .SYNC_STAGES(3), .FILT_CYC(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .flag(flag_b), .flag_rise(rise_b), .flag_fall(fall_b), .any_flag(any_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sst(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic int fct(input int c);
    return (c == 0) ? 4 : 1;
  endfunction

  // Reference: din seen through an N-sample delay line; flag follows cond after a disagreement
  // streak of FILT_CYC cycles, and is forced low while en is low.
  logic [7:0]    m_hist [2][CH];
  int            m_run  [2][CH];
  logic [CH-1:0] m_flag [2];
  logic [CH-1:0] m_rise [2];
  logic [CH-1:0] m_fall [2];

  always @(posedge clk or posedge rst) begin : ref_model
    logic [7:0]    h_n  [2][CH];
    int            r_n  [2][CH];
    logic [CH-1:0] f_n  [2];
    logic [CH-1:0] ri_n [2];
    logic [CH-1:0] fa_n [2];
    logic          ds, cnd, old;
    if (rst) begin
      m_hist <= '{default: '0};
      m_run  <= '{default: 0};
      m_flag <= '{default: '0};
      m_rise <= '{default: '0};
      m_fall <= '{default: '0};
    end else begin
      h_n = m_hist;
      r_n = m_run;
      f_n = m_flag;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < int'(CH); i++) begin
          ds  = h_n[c][i][sst(c)-1];
          cnd = ds & en[i];
          old = f_n[c][i];
          if (!en[i]) begin
            f_n[c][i] = 1'b0;
            r_n[c][i] = 0;
          end else if (cnd == old) begin
            r_n[c][i] = 0;
          end else begin
            r_n[c][i] = r_n[c][i] + 1;
            if (r_n[c][i] >= fct(c)) begin
              f_n[c][i] = cnd;
              r_n[c][i] = 0;
            end
          end
          h_n[c][i]  = {h_n[c][i][6:0], din[i]};
          ri_n[c][i] = f_n[c][i] & ~old;
          fa_n[c][i] = ~f_n[c][i] & old;
        end
      end
      m_hist <= h_n;
      m_run  <= r_n;
      m_flag <= f_n;
      m_rise <= ri_n;
      m_fall <= fa_n;
    end
  end

  always @(negedge clk) begin
    check("flag_a", 32'(flag_a), 32'(m_flag[0]));
    check("rise_a", 32'(rise_a), 32'(m_rise[0]));
    check("fall_a", 32'(fall_a), 32'(m_fall[0]));
    check("any_a",  32'(any_a),  32'(|m_flag[0]));
    check("flag_b", 32'(flag_b), 32'(m_flag[1]));
    check("rise_b", 32'(rise_b), 32'(m_rise[1]));
    check("fall_b", 32'(fall_b), 32'(m_fall[1]));
    check("any_b",  32'(any_b),  32'(|m_flag[1]));
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held with all inputs active: outputs stay low.
    repeat (3) begin
      @(negedge clk);
      check("rst_flag", 32'(flag_a), 32'(0));
      check("rst_pulse", 32'({rise_a, fall_a}), 32'(0));
      check("rst_any", 32'(any_a), 32'(0));
    end
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("t1_flag_a", 32'(flag_a), (e >= 6) ? 32'hF : 32'h0);
      check("t1_flag_b", 32'(flag_b), (e >= 4) ? 32'hF : 32'h0);
      check("t1_rise_b", 32'(rise_b), (e == 4) ? 32'hF : 32'h0);
    end

    // Latency on ch0.
    din = 4'h0;
    repeat (10) step();
    din = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      step();
      check("t2_flag0", 32'(flag_a[0]), 32'(e >= 6));
      check("t2_rise0", 32'(rise_a[0]), 32'(e == 6));
      check("t2_any",   32'(any_a),     32'(e >= 6));
    end

    // Three-cycle glitch on ch1 is rejected, a long pulse is not.
    din = 4'b0011;
    repeat (3) step();
    din = 4'b0001;
    for (int e = 0; e < 8; e++) begin
      step();
      check("t3_glitch", 32'(flag_a[1]), 32'(0));
    end
    din = 4'b0011;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("t3_hold", 32'(flag_a[1]), 32'(e >= 6));
    end

    // Enable kill on ch2 while din toggles.
    din = 4'b0111;
    repeat (8) step();
    check("t4_set", 32'(flag_a[2]), 32'(1));
    din[2] = 1'b0;
    step();
    din[2] = 1'b1;
    step();
    din[2] = 1'b0;
    en[2]  = 1'b0;
    step();
    check("t4_kill", 32'(flag_a[2]), 32'(0));
    check("t4_fall", 32'(fall_a[2]), 32'(1));
    din[2] = 1'b1;
    en[2]  = 1'b1;
    repeat (8) step();
    check("t4_reset", 32'(flag_a[2]), 32'(1));

    // Asynchronous reset with two counted cycles in flight.
    din = 4'hF;
    repeat (8) step();
    check("t5_pre", 32'(flag_a), 32'hF);
    din = 4'h0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_flag", 32'(flag_a), 32'h0);
    check("t5_async_any",  32'(any_a),  32'h0);
    check("t5_async_b",    32'(flag_b), 32'h0);
    @(negedge clk);
    din = 4'hF;
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("t5_lat", 32'(flag_a), (e >= 6) ? 32'hF : 32'h0);
    end

    // Simultaneous rise on ch0 and fall on ch3.
    din = 4'b1000;
    repeat (10) step();
    check("t6_pre", 32'(flag_a), 32'h8);
    din = 4'b0001;
    for (int e = 1; e <= 6; e++) begin
      step();
      check("t6_rise", 32'(rise_a), (e == 6) ? 32'h1 : 32'h0);
      check("t6_fall", 32'(fall_a), (e == 6) ? 32'h8 : 32'h0);
      check("t6_flag", 32'(flag_a), (e == 6) ? 32'h1 : 32'h8);
    end
    check("t6_any", 32'(any_a), 32'(1));

    // Random phase with occasional mid-cycle async reset.
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < int'(CH); i++) begin
        if ($urandom_range(4, 0) == 0) din[i] = ~din[i];
        if ($urandom_range(15, 0) == 0) en[i] = ~en[i];
      end
      if (k % 300 == 150) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rnd_async", 32'({flag_a, flag_b}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
